uart_fifo_sched: RTL and testbench
==================================

// Module: uart_fifo_sched
// PURPOSE
//  Owns both ports of one fifo_archsyn instance (wr/rd clocks both tied to i_clk) in the UART TX path.
//  Shares the FIFO write port among NUM_REQ requesters via round-robin; drains the read port into a
//  valid/ready byte stream for the UART TX shifter. Sits between host/loopback byte sources and uart_tx.
// PARAMETERS
//  SIZE_DATA   8   byte width, equals FIFO SIZE_DATA
//  SIZE_DEPTH  16  FIFO depth, used only by level counter
//  NUM_REQ     2   number of write requesters (>=2)
//  AF_THRESH   12  almost-full level (level counter only)
// PORTS
//  i_clk           in   1                  clock
//  i_rst           in   1                  synchronous, active-high reset
//  i_req           in   NUM_REQ            per-requester write request; held with data until granted
//  i_req_data      in   NUM_REQ*SIZE_DATA  packed write data, requester k at [k*SIZE_DATA +: SIZE_DATA]
//  o_gnt           out  NUM_REQ            one-hot grant = byte accepted this cycle
//  o_fifo_wr_en    out  1                  to FIFO i_wr_en
//  o_fifo_wdata    out  SIZE_DATA          to FIFO i_data
//  i_fifo_full     in   1                  from FIFO o_fifo_full
//  o_fifo_rd_en    out  1                  to FIFO i_rd_en
//  i_fifo_rdata    in   SIZE_DATA          from FIFO o_data, valid 1 cycle after rd_en
//  i_fifo_empty    in   1                  from FIFO o_fifo_empty
//  o_tx_valid      out  1                  byte available to TX shifter
//  o_tx_data       out  SIZE_DATA          byte, stable while o_tx_valid & !i_tx_ready
//  i_tx_ready      in   1                  TX shifter accepts when valid & ready
//  o_level         out  $clog2(SIZE_DEPTH)+1  occupancy (feature)
//  o_almost_full   out  1                  o_level >= AF_THRESH (feature)
// BEHAVIOUR
//  Reset: o_gnt=0, o_fifo_wr_en=0, o_fifo_rd_en=0, o_tx_valid=0, o_tx_data=0, o_level=0,
//   o_almost_full=0; RR pointer=0; FSM=IDLE. Reset mid-operation drops any byte held in o_tx_data.
//  Write arbiter (combinational grant): if i_fifo_full=1 -> o_gnt=0. Otherwise grant the first
//   asserted i_req at or after pointer (wrapping NUM_REQ-1 -> 0); o_fifo_wr_en=|o_gnt;
//   o_fifo_wdata=granted requester's data. On a grant to k, pointer <= (k+1) mod NUM_REQ; else it holds.
//  Read FSM (states IDLE, FETCH, HOLD):
//   IDLE : i_fifo_empty=0 -> o_fifo_rd_en=1 (1 cycle pulse), -> FETCH.
//   FETCH: o_tx_data <= i_fifo_rdata, o_tx_valid <= 1, -> HOLD.
//   HOLD : i_tx_ready=1 -> o_tx_valid <= 0; if i_fifo_empty=0 also pulse o_fifo_rd_en, -> FETCH; else -> IDLE.
//          i_tx_ready=0 -> stay, data held.
//  Throughput: at most one byte per 2 cycles; first byte valid 2 cycles after empty deasserts.
//  o_fifo_rd_en is never asserted while i_fifo_empty=1. o_fifo_wr_en is never asserted while i_fifo_full=1.
//  Simultaneous write and read in one cycle are permitted and independent.
// CONFIGURATION
//  UART_FIFO_LEVEL_EN defined: o_level counts +1 per write, -1 per read, net 0 on both, saturating at 0..SIZE_DEPTH;
//   o_almost_full registered from the next-level value.
//  Undefined: counter not built; o_level and o_almost_full tied 0 (ports always present).
// STRUCTURE
//  uart_sched_pkg: typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_e; localparam default widths.
//  Sub-module rr_arbiter #(N): i_req, i_en (=!full), o_gnt; internal pointer. Read FSM and counter inline.
// TESTING
//  1 Reset: i_rst=1 for 2 cycles with i_req=2'b11 -> all outputs 0, no grant during reset.
//  2 RR fairness: i_req=2'b11 held for 4 cycles, FIFO not full -> o_gnt 01,10,01,10.
//  3 Full: i_fifo_full=1, i_req=2'b01 -> o_gnt=0, o_fifo_wr_en=0; full drops -> grant same cycle.
//  4 Drain: FIFO holds 0xA5,0x3C, i_tx_ready=1 -> tx accepts 0xA5 then 0x3C, 2 cycles apart; FSM returns to IDLE.
//  5 Backpressure: i_tx_ready=0 for 5 cycles with valid -> o_tx_data stable, no rd_en; ready=1 -> next byte fetched.
//  6 UART_FIFO_LEVEL_EN: 12 writes, no reads -> o_level=12, o_almost_full=1; one read -> 11, almost_full=0.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and default widths for the UART TX FIFO scheduler.
package uart_sched_pkg;

    localparam int unsigned DEF_SIZE_DATA  = 8;
    localparam int unsigned DEF_SIZE_DEPTH = 16;
    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_AF_THRESH  = 12;

    // Read-side drain FSM states
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a combinational one-hot grant. The search starts at the pointer and
// wraps; the pointer moves to one past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic          found;

    // First asserted request at or after the pointer wins
    always_comb begin
        o_gnt   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (i_en) begin
            for (int i = 0; i < int'(N); i++) begin
                idx = PW'((int'(ptr_q) + i) % int'(N));
                if (!found && i_req[idx]) begin
                    found      = 1'b1;
                    o_gnt[idx] = 1'b1;
                    gnt_idx    = idx;
                end
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_fifo_sched.sv
// UART TX FIFO scheduler: round-robin write-port sharing plus a read drain into a valid/ready
// byte stream. Optional occupancy counter enabled by defining UART_FIFO_LEVEL_EN; without it
// o_level and o_almost_full are tied low.
module uart_fifo_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned SIZE_DATA  = DEF_SIZE_DATA,
    parameter int unsigned SIZE_DEPTH = DEF_SIZE_DEPTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned AF_THRESH  = DEF_AF_THRESH
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic                           o_fifo_wr_en,
    output logic [SIZE_DATA-1:0]           o_fifo_wdata,
    input  logic                           i_fifo_full,
    output logic                           o_fifo_rd_en,
    input  logic [SIZE_DATA-1:0]           i_fifo_rdata,
    input  logic                           i_fifo_empty,
    output logic                           o_tx_valid,
    output logic [SIZE_DATA-1:0]           o_tx_data,
    input  logic                           i_tx_ready,
    output logic [$clog2(SIZE_DEPTH):0]    o_level,
    output logic                           o_almost_full
);

    localparam int unsigned LVL_W = $clog2(SIZE_DEPTH) + 1;

    if (NUM_REQ < 2 || AF_THRESH > SIZE_DEPTH) begin : g_bad_cfg
        $error("uart_fifo_sched: NUM_REQ must be >= 2 and AF_THRESH <= SIZE_DEPTH");
    end

    // ---------------- write side ----------------
    logic arb_en;

    // No grants while full or while reset is held
    assign arb_en = !i_fifo_full && !i_rst;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req),
        .i_en  (arb_en),
        .o_gnt (o_gnt)
    );

    assign o_fifo_wr_en = |o_gnt;

    // Forward the granted requester's byte
    always_comb begin
        o_fifo_wdata = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (o_gnt[k]) begin
                o_fifo_wdata = i_req_data[k*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_e            state_q, state_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [SIZE_DATA-1:0] tx_data_q, tx_data_d;
    logic                 rd_en;

    // Drain FSM: pulse rd_en, capture next cycle, hold until the shifter takes it
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rd_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!i_fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                tx_data_d  = i_fifo_rdata;
                tx_valid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (!i_fifo_empty) begin
                        rd_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM state and output byte registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_fifo_rd_en = rd_en && !i_rst;
    assign o_tx_valid   = tx_valid_q;
    assign o_tx_data    = tx_data_q;

    // ---------------- occupancy ----------------
`ifdef UART_FIFO_LEVEL_EN
    logic [LVL_W-1:0] level_q, level_d;
    logic             af_q;

    // Saturating up/down count; simultaneous write and read cancel
    always_comb begin
        level_d = level_q;
        if (o_fifo_wr_en && !o_fifo_rd_en && level_q != LVL_W'(SIZE_DEPTH)) begin
            level_d = level_q + 1'b1;
        end else if (!o_fifo_wr_en && o_fifo_rd_en && level_q != '0) begin
            level_d = level_q - 1'b1;
        end
    end

    // Level and almost-full registers (almost-full looks at the next level)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= (level_d >= LVL_W'(AF_THRESH));
        end
    end

    assign o_level       = level_q;
    assign o_almost_full = af_q;
`else
    assign o_level       = '0;
    assign o_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Self-checking bench for uart_fifo_sched with a behavioural FIFO model and a byte scoreboard.
module tb_uart_fifo_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  gnt;
    logic        wr_en;
    logic [7:0]  wdata;
    logic        fifo_full;
    logic        rd_en;
    logic [7:0]  rdata_r = 8'h00;
    logic        fifo_empty;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [4:0]  level;
    logic        af;

    always #5 clk = ~clk;

    uart_fifo_sched dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_req_data    (req_data),
        .o_gnt         (gnt),
        .o_fifo_wr_en  (wr_en),
        .o_fifo_wdata  (wdata),
        .i_fifo_full   (fifo_full),
        .o_fifo_rd_en  (rd_en),
        .i_fifo_rdata  (rdata_r),
        .i_fifo_empty  (fifo_empty),
        .o_tx_valid    (tx_valid),
        .o_tx_data     (tx_data),
        .i_tx_ready    (tx_ready),
        .o_level       (level),
        .o_almost_full (af)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural FIFO: data valid one cycle after rd_en; overrides force full/empty flags
    logic [7:0] fq[$];
    int         fcnt = 0;
    logic       force_full = 1'b0;
    logic       force_empty = 1'b0;

    assign fifo_full  = force_full || (fcnt >= 16);
    assign fifo_empty = force_empty || (fcnt == 0);

    always @(posedge clk) begin
        if (!rst) begin
            check_eq("rd_while_empty", 32'(rd_en && fifo_empty), 32'd0);
            check_eq("wr_while_full", 32'(wr_en && fifo_full), 32'd0);
        end
        if (rd_en && fq.size() > 0) rdata_r <= fq.pop_front();
        if (wr_en) fq.push_back(wdata);
        fcnt <= fq.size();
    end

    // Scoreboard: bytes expected on the TX handshake, in order
    logic [7:0] exp_q[$];
    int cyc = 0;
    int hs_count = 0;
    int last_hs = 0;
    int prev_hs = 0;

    always @(posedge clk) begin
        logic [31:0] e;
        cyc++;
        if (!rst && tx_valid && tx_ready) begin
            e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            check_eq("tx_byte", 32'(tx_data), e);
            prev_hs = last_hs;
            last_hs = cyc;
            hs_count++;
        end
    end

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int hs0;

        // 1: reset with requests pending
        rst = 1'b1;
        req = 2'b11;
        req_data = {8'h22, 8'h11};
        tx_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_eq("rst_gnt", 32'(gnt), 32'd0);
            check_eq("rst_wr_en", 32'(wr_en), 32'd0);
            check_eq("rst_rd_en", 32'(rd_en), 32'd0);
            check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
            check_eq("rst_tx_data", 32'(tx_data), 32'd0);
            check_eq("rst_level", 32'(level), 32'd0);
            check_eq("rst_af", 32'(af), 32'd0);
        end

        // 2: round-robin with both requesters held
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req = 2'b11;
            req_data = {8'(8'h20 + i), 8'(8'h10 + i)};
            #1;
            b = (i % 2 == 0) ? 8'(8'h10 + i) : 8'(8'h20 + i);
            check_eq("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("rr_wr_en", 32'(wr_en), 32'd1);
            check_eq("rr_wdata", 32'(wdata), 32'(b));
            exp_q.push_back(b);
        end
        @(negedge clk);
        req = 2'b00;

        // 5: backpressure holds the first byte, no further reads
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp_valid", 32'(tx_valid), 32'd1);
            check_eq("bp_data", 32'(tx_data), 32'(exp_q[0]));
            check_eq("bp_rd_en", 32'(rd_en), 32'd0);
`ifdef UART_FIFO_LEVEL_EN
            check_eq("bp_level", 32'(level), 32'd3);
`else
            check_eq("bp_level_off", 32'(level), 32'd0);
`endif
            check_eq("bp_af", 32'(af), 32'd0);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check_eq("bp_release_rd_en", 32'(rd_en), 32'd1);
        drain("bp_drain", 40);
        repeat (3) @(negedge clk);
        #1;
        check_eq("idle_valid", 32'(tx_valid), 32'd0);
        check_eq("idle_rd_en", 32'(rd_en), 32'd0);

        // 3: full blocks grants; release grants in the same cycle
        @(negedge clk);
        force_full = 1'b1;
        req = 2'b01;
        req_data = {8'h00, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("full_gnt", 32'(gnt), 32'd0);
            check_eq("full_wr_en", 32'(wr_en), 32'd0);
            @(negedge clk);
        end
        force_full = 1'b0;
        #1;
        check_eq("unfull_gnt", 32'(gnt), 32'd1);
        check_eq("unfull_wr_en", 32'(wr_en), 32'd1);
        check_eq("unfull_wdata", 32'(wdata), 32'h5A);
        exp_q.push_back(8'h5A);
        @(negedge clk);
        req = 2'b00;
        drain("full_drain", 20);
        repeat (3) @(negedge clk);

        // 4: two bytes drained back to back, two cycles apart
        hs0 = hs_count;
        @(negedge clk);
        req = 2'b01;
        req_data = {8'h00, 8'hA5};
        #1;
        check_eq("drain_gnt0", 32'(gnt), 32'd1);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        req = 2'b10;
        req_data = {8'h3C, 8'h00};
        #1;
        check_eq("drain_gnt1", 32'(gnt), 32'd2);
        exp_q.push_back(8'h3C);
        @(negedge clk);
        req = 2'b00;
        for (int k = 0; k < 20 && hs_count < hs0 + 2; k++) @(negedge clk);
        check_eq("drain_hs_count", 32'(hs_count - hs0), 32'd2);
        check_eq("drain_spacing", 32'(last_hs - prev_hs), 32'd2);
        repeat (2) @(negedge clk);
        #1;
        check_eq("drain_idle_valid", 32'(tx_valid), 32'd0);
        check_eq("drain_idle_rd_en", 32'(rd_en), 32'd0);

`ifdef UART_FIFO_LEVEL_EN
        // 6: occupancy and almost-full
        @(negedge clk);
        tx_ready = 1'b0;
        force_empty = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req = 2'b01;
            req_data = {8'h00, 8'(8'h40 + i)};
            #1;
            check_eq("lvl_gnt", 32'(gnt), 32'd1);
            exp_q.push_back(8'(8'h40 + i));
            @(negedge clk);
        end
        req = 2'b00;
        #1;
        check_eq("lvl_12", 32'(level), 32'd12);
        check_eq("af_12", 32'(af), 32'd1);
        force_empty = 1'b0;
        @(negedge clk);
        #1;
        check_eq("lvl_11", 32'(level), 32'd11);
        check_eq("af_11", 32'(af), 32'd0);
        tx_ready = 1'b1;
        drain("lvl_drain", 60);
        repeat (3) @(negedge clk);
        #1;
        check_eq("lvl_0", 32'(level), 32'd0);
`endif

        // Reset mid-operation drops the held byte
        @(negedge clk);
        tx_ready = 1'b0;
        req = 2'b01;
        req_data = {8'h00, 8'h99};
        #1;
        check_eq("mid_gnt", 32'(gnt), 32'd1);
        @(negedge clk);
        req = 2'b00;
        for (int k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
        check_eq("mid_valid", 32'(tx_valid), 32'd1);
        check_eq("mid_data", 32'(tx_data), 32'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_rst_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
